// File: rtl/mem_ctrl.sv
// Byte-wide RAM/IO bus sequencer serving instruction fetches and LSB loads/stores.
// Requests are latched as pending. The LSB port has priority whenever the bus is idle.
module mem_ctrl #(
    parameter int         ADDR_W = 32,
    parameter int         DATA_W = 32,
    parameter logic [1:0] IO_SEL = 2'b11
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              start_sign_from_if,
    input  logic [ADDR_W-1:0] pc_from_if,
    output logic              finish_sign_to_if,
    output logic [DATA_W-1:0] inst_to_if,
    input  logic              start_sign_from_lsb,
    input  logic              wr_sign_from_lsb,
    input  logic [ADDR_W-1:0] addr_from_lsb,
    input  logic [1:0]        size_from_lsb,
    input  logic [DATA_W-1:0] data_from_lsb,
    output logic              finish_sign_to_lsb,
    output logic [DATA_W-1:0] data_to_lsb,
    input  logic              rollback_sign_from_ROB,
    input  logic [7:0]        mem_din,
    output logic [7:0]        mem_dout,
    output logic [ADDR_W-1:0] mem_a,
    output logic              mem_wr,
    input  logic              io_buffer_full
);

    typedef enum logic [1:0] {IDLE, IF_READ, LSB_READ, LSB_WRITE} state_t;

    state_t              state;
    logic                pending_if;
    logic [ADDR_W-1:0]   pc_pend;
    logic                pending_lsb;
    logic                pend_wr;
    logic [ADDR_W-1:0]   pend_addr;
    logic [1:0]          pend_size;
    logic [DATA_W-1:0]   pend_data;
    logic [ADDR_W-1:0]   op_addr;
    logic [DATA_W-1:0]   op_data;
    logic [2:0]          n_bytes;
    logic [2:0]          step;
    logic [DATA_W-1:0]   rd_buf;
    logic [DATA_W-1:0]   buf_next;
    logic [1:0]          lane;
    logic                mem_wr_q;
    logic                rollback;

    assign rollback = rollback_sign_from_ROB;
    assign mem_wr   = mem_wr_q & rdy;

    function automatic logic [2:0] size_to_n(input logic [1:0] size);
        case (size)
            2'd0:    size_to_n = 3'd1;
            2'd1:    size_to_n = 3'd2;
            default: size_to_n = 3'd4;
        endcase
    endfunction

    function automatic logic io_stall(input logic [ADDR_W-1:0] addr, input logic full);
        io_stall = (addr[17:16] == IO_SEL) && full;
    endfunction

    // Byte arriving on mem_din belongs to the address issued two edges earlier.
    always_comb begin
        lane     = step[1:0] - 2'd2;
        buf_next = rd_buf;
        buf_next[{lane, 3'b000} +: 8] = mem_din;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state              <= IDLE;
            pending_if         <= 1'b0;
            pc_pend            <= '0;
            pending_lsb        <= 1'b0;
            pend_wr            <= 1'b0;
            pend_addr          <= '0;
            pend_size          <= '0;
            pend_data          <= '0;
            op_addr            <= '0;
            op_data            <= '0;
            n_bytes            <= '0;
            step               <= '0;
            rd_buf             <= '0;
            mem_wr_q           <= 1'b0;
            mem_a              <= '0;
            mem_dout           <= '0;
            finish_sign_to_if  <= 1'b0;
            finish_sign_to_lsb <= 1'b0;
            inst_to_if         <= '0;
            data_to_lsb        <= '0;
        end else if (rdy) begin
            finish_sign_to_if  <= 1'b0;
            finish_sign_to_lsb <= 1'b0;
            case (state)
                IDLE: begin
                    if (pending_lsb && !(rollback && !pend_wr)) begin
                        pending_lsb <= 1'b0;
                        op_data     <= pend_data;
                        n_bytes     <= size_to_n(pend_size);
                        rd_buf      <= '0;
                        if (pend_wr) begin
                            state <= LSB_WRITE;
                            if (io_stall(pend_addr, io_buffer_full)) begin
                                mem_wr_q <= 1'b0;
                                op_addr  <= pend_addr;
                                step     <= 3'd0;
                            end else begin
                                mem_a    <= pend_addr;
                                mem_dout <= pend_data[7:0];
                                mem_wr_q <= 1'b1;
                                op_addr  <= pend_addr + ADDR_W'(1);
                                step     <= 3'd1;
                            end
                        end else begin
                            state <= LSB_READ;
                            mem_a <= pend_addr;
                            step  <= 3'd1;
                        end
                    end else if (pending_if && !rollback) begin
                        pending_if <= 1'b0;
                        state      <= IF_READ;
                        mem_a      <= pc_pend;
                        n_bytes    <= 3'd4;
                        rd_buf     <= '0;
                        step       <= 3'd1;
                    end
                end
                IF_READ, LSB_READ: begin
                    if (rollback) begin
                        state <= IDLE;
                    end else begin
                        if (step < n_bytes) mem_a <= mem_a + ADDR_W'(1);
                        if (step >= 3'd2) rd_buf <= buf_next;
                        if (step == n_bytes + 3'd1) begin
                            state <= IDLE;
                            if (state == IF_READ) begin
                                inst_to_if        <= buf_next;
                                finish_sign_to_if <= 1'b1;
                            end else begin
                                data_to_lsb        <= buf_next;
                                finish_sign_to_lsb <= 1'b1;
                            end
                        end
                        step <= step + 3'd1;
                    end
                end
                LSB_WRITE: begin
                    if (step == n_bytes) begin
                        mem_wr_q           <= 1'b0;
                        finish_sign_to_lsb <= 1'b1;
                        state              <= IDLE;
                    end else if (io_stall(op_addr, io_buffer_full)) begin
                        mem_wr_q <= 1'b0;
                    end else begin
                        mem_a    <= op_addr;
                        mem_dout <= op_data[{step[1:0], 3'b000} +: 8];
                        mem_wr_q <= 1'b1;
                        op_addr  <= op_addr + ADDR_W'(1);
                        step     <= step + 3'd1;
                    end
                end
                default: state <= IDLE;
            endcase

            // Rollback kills speculative fetches/loads; committed stores survive.
            if (rollback) begin
                pending_if <= 1'b0;
                if (!pend_wr) pending_lsb <= 1'b0;
            end
            if (start_sign_from_if && !rollback) begin
                pending_if <= 1'b1;
                pc_pend    <= pc_from_if;
            end
            if (start_sign_from_lsb && !(rollback && !wr_sign_from_lsb)) begin
                pending_lsb <= 1'b1;
                pend_wr     <= wr_sign_from_lsb;
                pend_addr   <= addr_from_lsb;
                pend_size   <= size_from_lsb;
                pend_data   <= data_from_lsb;
            end
        end
    end

endmodule

// File: tb/tb_mem_ctrl.sv
// Scoreboard bench for mem_ctrl: stimulus pushes expected responses, a negedge monitor pops them.
module tb_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rdy = 1'b1;
    logic        start_sign_from_if = 1'b0;
    logic [31:0] pc_from_if = '0;
    logic        finish_sign_to_if;
    logic [31:0] inst_to_if;
    logic        start_sign_from_lsb = 1'b0;
    logic        wr_sign_from_lsb = 1'b0;
    logic [31:0] addr_from_lsb = '0;
    logic [1:0]  size_from_lsb = '0;
    logic [31:0] data_from_lsb = '0;
    logic        finish_sign_to_lsb;
    logic [31:0] data_to_lsb;
    logic        rollback_sign_from_ROB = 1'b0;
    logic [7:0]  mem_din = '0;
    logic [7:0]  mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic        io_buffer_full = 1'b0;

    mem_ctrl dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .start_sign_from_if(start_sign_from_if), .pc_from_if(pc_from_if),
        .finish_sign_to_if(finish_sign_to_if), .inst_to_if(inst_to_if),
        .start_sign_from_lsb(start_sign_from_lsb), .wr_sign_from_lsb(wr_sign_from_lsb),
        .addr_from_lsb(addr_from_lsb), .size_from_lsb(size_from_lsb),
        .data_from_lsb(data_from_lsb), .finish_sign_to_lsb(finish_sign_to_lsb),
        .data_to_lsb(data_to_lsb), .rollback_sign_from_ROB(rollback_sign_from_ROB),
        .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
        .io_buffer_full(io_buffer_full)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        int          cyc;
        bit          chk;
    } rsp_t;
    typedef struct {
        logic [31:0] addr;
        logic [7:0]  data;
        int          cyc;
    } wr_t;

    rsp_t exp_if[$];
    rsp_t exp_lsb[$];
    wr_t  exp_wr[$];
    rsp_t e_if, e_lsb;
    wr_t  e_wr;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic [7:0] ram [0:65535];

    // RAM: one-cycle read latency; IO space writes are not stored.
    always @(posedge clk) begin
        cyc = cyc + 1;
        mem_din <= ram[mem_a[15:0]];
        if (mem_wr && mem_a[17:16] != 2'b11) ram[mem_a[15:0]] <= mem_dout;
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (finish_sign_to_if) begin
                checks++;
                if (exp_if.size() == 0) begin
                    errors++;
                    $display("FAIL if_unexpected: inst=%h at cycle %0d, none required", inst_to_if, cyc);
                end else begin
                    e_if = exp_if.pop_front();
                    if (inst_to_if !== e_if.data || cyc != e_if.cyc) begin
                        errors++;
                        $display("FAIL if_finish: got inst=%h cycle=%0d, required inst=%h cycle=%0d",
                                 inst_to_if, cyc, e_if.data, e_if.cyc);
                    end
                end
            end
            if (finish_sign_to_lsb) begin
                checks++;
                if (exp_lsb.size() == 0) begin
                    errors++;
                    $display("FAIL lsb_unexpected: data=%h at cycle %0d, none required", data_to_lsb, cyc);
                end else begin
                    e_lsb = exp_lsb.pop_front();
                    if ((e_lsb.chk && data_to_lsb !== e_lsb.data) || cyc != e_lsb.cyc) begin
                        errors++;
                        $display("FAIL lsb_finish: got data=%h cycle=%0d, required data=%h cycle=%0d",
                                 data_to_lsb, cyc, e_lsb.data, e_lsb.cyc);
                    end
                end
            end
            if (mem_wr) begin
                checks++;
                if (exp_wr.size() == 0) begin
                    errors++;
                    $display("FAIL wr_unexpected: a=%h d=%h at cycle %0d", mem_a, mem_dout, cyc);
                end else begin
                    e_wr = exp_wr.pop_front();
                    if (mem_a !== e_wr.addr || mem_dout !== e_wr.data || cyc != e_wr.cyc) begin
                        errors++;
                        $display("FAIL wr_byte: got a=%h d=%h cycle=%0d, required a=%h d=%h cycle=%0d",
                                 mem_a, mem_dout, cyc, e_wr.addr, e_wr.data, e_wr.cyc);
                    end
                end
            end
        end
    end

    // Each task returns L, the edge number at which the request pulse is latched.
    task automatic issue_if(input logic [31:0] pc, output int l);
        @(negedge clk);
        l = cyc + 1;
        start_sign_from_if = 1'b1;
        pc_from_if = pc;
        @(negedge clk);
        start_sign_from_if = 1'b0;
    endtask

    task automatic issue_lsb(input logic wr, input logic [31:0] a, input logic [1:0] sz,
                             input logic [31:0] d, output int l);
        @(negedge clk);
        l = cyc + 1;
        start_sign_from_lsb = 1'b1;
        wr_sign_from_lsb = wr;
        addr_from_lsb = a;
        size_from_lsb = sz;
        data_from_lsb = d;
        @(negedge clk);
        start_sign_from_lsb = 1'b0;
    endtask

    task automatic push_rsp(input bit is_if, input logic [31:0] d, input int c, input bit chk);
        rsp_t r;
        r.data = d;
        r.cyc = c;
        r.chk = chk;
        if (is_if) exp_if.push_back(r);
        else exp_lsb.push_back(r);
    endtask

    task automatic push_wr(input logic [31:0] a, input logic [7:0] d, input int c);
        wr_t w;
        w.addr = a;
        w.data = d;
        w.cyc = c;
        exp_wr.push_back(w);
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 60; i++) begin
            if (exp_if.size() == 0 && exp_lsb.size() == 0 && exp_wr.size() == 0) break;
            @(negedge clk);
        end
        checks++;
        if (exp_if.size() != 0 || exp_lsb.size() != 0 || exp_wr.size() != 0) begin
            errors++;
            $display("FAIL %s_timeout: outstanding if=%0d lsb=%0d wr=%0d, required 0 0 0",
                     name, exp_if.size(), exp_lsb.size(), exp_wr.size());
            exp_if.delete();
            exp_lsb.delete();
            exp_wr.delete();
        end
        repeat (4) @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not end by itself");
        $fatal(1, "watchdog");
    end

    initial begin
        int l;
        int l2;
        for (int i = 0; i < 65536; i++) ram[i] = 8'h00;
        ram[4] = 8'h13; ram[5] = 8'h05; ram[6] = 8'h00; ram[7] = 8'h00;
        ram[8] = 8'h93; ram[9] = 8'h00; ram[10] = 8'h10; ram[11] = 8'h00;
        ram[16'h1000] = 8'h80; ram[16'h1001] = 8'h7F;

        repeat (3) @(negedge clk);
        checks++;
        if ({finish_sign_to_if, finish_sign_to_lsb, mem_wr, mem_a, mem_dout, inst_to_if, data_to_lsb} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: fi=%b fl=%b wr=%b a=%h d=%h inst=%h data=%h, required all 0",
                     finish_sign_to_if, finish_sign_to_lsb, mem_wr, mem_a, mem_dout, inst_to_if, data_to_lsb);
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({finish_sign_to_if, finish_sign_to_lsb, mem_wr} !== 3'b000) begin
            errors++;
            $display("FAIL idle_after_reset: fi=%b fl=%b wr=%b, required 000",
                     finish_sign_to_if, finish_sign_to_lsb, mem_wr);
        end

        // Fetch word at 0x4: finish edge L+6 (E0 = L+1, finish at E5).
        issue_if(32'h4, l);
        push_rsp(1'b1, 32'h0000_0513, l + 6, 1'b1);
        drain("fetch");

        // Load byte, zero-extended: finish at E2.
        issue_lsb(1'b0, 32'h1000, 2'd0, 32'h0, l);
        push_rsp(1'b0, 32'h0000_0080, l + 3, 1'b1);
        drain("load_byte");

        // Store word: bytes at E0..E3, finish at E4.
        issue_lsb(1'b1, 32'h2000, 2'd3, 32'hDEAD_BEEF, l);
        push_wr(32'h2000, 8'hEF, l + 1);
        push_wr(32'h2001, 8'hBE, l + 2);
        push_wr(32'h2002, 8'hAD, l + 3);
        push_wr(32'h2003, 8'hDE, l + 4);
        push_rsp(1'b0, 32'h0, l + 5, 1'b0);
        drain("store_word");

        // size=2 behaves as a 4-byte load; reads back the stored word.
        issue_lsb(1'b0, 32'h2000, 2'd2, 32'h0, l);
        push_rsp(1'b0, 32'hDEAD_BEEF, l + 6, 1'b1);
        drain("load_size2");

        // Simultaneous pulses: LSB halfword first (finish L+4), fetch dispatched L+5, finish L+10.
        @(negedge clk);
        l = cyc + 1;
        start_sign_from_if = 1'b1;
        pc_from_if = 32'h8;
        start_sign_from_lsb = 1'b1;
        wr_sign_from_lsb = 1'b0;
        addr_from_lsb = 32'h1000;
        size_from_lsb = 2'd1;
        @(negedge clk);
        start_sign_from_if = 1'b0;
        start_sign_from_lsb = 1'b0;
        push_rsp(1'b0, 32'h0000_7F80, l + 4, 1'b1);
        push_rsp(1'b1, 32'h0010_0093, l + 10, 1'b1);
        drain("simultaneous");

        // Rollback sampled two edges into a fetch: no finish, then a fresh fetch at 0x8.
        issue_if(32'h4, l);
        wait_until(l + 2);
        rollback_sign_from_ROB = 1'b1;
        @(negedge clk);
        rollback_sign_from_ROB = 1'b0;
        repeat (8) @(negedge clk);
        issue_if(32'h8, l2);
        push_rsp(1'b1, 32'h0010_0093, l2 + 6, 1'b1);
        drain("rollback");

        // IO store stalled for three edges while the buffer is full.
        @(negedge clk);
        io_buffer_full = 1'b1;
        issue_lsb(1'b1, 32'h0003_0000, 2'd0, 32'h0000_0041, l);
        push_wr(32'h0003_0000, 8'h41, l + 4);
        push_rsp(1'b0, 32'h0, l + 5, 1'b0);
        wait_until(l + 3);
        io_buffer_full = 1'b0;
        drain("io_stall");

        // Halfword store then a 4-byte read across it.
        issue_lsb(1'b1, 32'h2002, 2'd1, 32'h1234_5678, l);
        push_wr(32'h2002, 8'h78, l + 1);
        push_wr(32'h2003, 8'h56, l + 2);
        push_rsp(1'b0, 32'h0, l + 3, 1'b0);
        drain("store_half");
        issue_lsb(1'b0, 32'h2000, 2'd3, 32'h0, l);
        push_rsp(1'b0, 32'h5678_BEEF, l + 6, 1'b1);
        drain("load_word");

        // rdy low for two edges mid-fetch delays completion by two cycles.
        issue_if(32'h4, l);
        wait_until(l + 1);
        rdy = 1'b0;
        wait_until(l + 3);
        rdy = 1'b1;
        push_rsp(1'b1, 32'h0000_0513, l + 8, 1'b1);
        drain("freeze");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
